// File: rtl/request_scheduler_if.sv
// Requester/resource handshake bundle for request_scheduler.
// master: scheduler side; slave: requesters plus resource.
interface request_scheduler_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] req_cancel;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   owner;
  logic               request;
  logic               accept;
  logic               cancel;
  logic               done;
  logic               busy;

  modport master (
    input  req, req_cancel, accept, done,
    output grant, owner, request, cancel, busy
  );

  modport slave (
    output req, req_cancel, accept, done,
    input  grant, owner, request, cancel, busy
  );
endinterface

// File: rtl/request_scheduler.sv
// Round-robin arbiter driving a request/accept/cancel/done resource handshake.
// Optional embedded properties: define REQUEST_SCHEDULER_SVA_EN.
module request_scheduler #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned ACCEPT_TIMEOUT = 16
) (
  input logic                  clk,
  input logic                  rst,
  request_scheduler_if.master  bus
);
  localparam int unsigned IDX_W  = $clog2(NUM_REQ);
  localparam int unsigned TIMERW = $clog2(ACCEPT_TIMEOUT + 1);

  typedef enum logic [2:0] {StIdle, StReq, StWaitAcc, StCancel, StBusy} state_e;

  state_e             state_q;
  logic [TIMERW-1:0]  timer_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   owner_q;
  logic [NUM_REQ-1:0] grant_q;
  logic               request_q;
  logic               cancel_q;
  logic               busy_q;

  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   cand_idx;
  int unsigned        cand;
  logic               own_cancel;
  logic               timed_out;

  // First set req bit searching upward from ptr_q+1, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand     = (32'(ptr_q) + i) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!win_found && bus.req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  assign own_cancel = bus.req_cancel[owner_q];
  assign timed_out  = (timer_q == TIMERW'(ACCEPT_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      ptr_q     <= IDX_W'(NUM_REQ - 1);
      owner_q   <= '0;
      grant_q   <= '0;
      request_q <= 1'b0;
      cancel_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      request_q <= 1'b0;
      cancel_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (win_found) begin
            owner_q   <= win_idx;
            ptr_q     <= win_idx;
            grant_q   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
            request_q <= 1'b1;
            state_q   <= StReq;
          end
        end
        StReq: begin
          timer_q <= '0;
          state_q <= StWaitAcc;
        end
        StWaitAcc: begin
          // accept wins: cancel has not been driven yet this cycle
          if (bus.accept) begin
            busy_q  <= 1'b1;
            state_q <= StBusy;
          end else if (own_cancel || timed_out) begin
            cancel_q <= 1'b1;
            state_q  <= StCancel;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        StCancel: begin
          grant_q <= '0;
          state_q <= StIdle;
        end
        StBusy: begin
          if (bus.done) begin
            busy_q  <= 1'b0;
            grant_q <= '0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.grant   = grant_q;
  assign bus.owner   = owner_q;
  assign bus.request = request_q;
  assign bus.cancel  = cancel_q;
  assign bus.busy    = busy_q;

`ifdef REQUEST_SCHEDULER_SVA_EN
  default clocking cb @(posedge clk); endclocking
  default disable iff (rst);

  sequence s_accepted;
    bus.request ##1 (!bus.cancel throughout bus.accept[->1]);
  endsequence

  a_accept_to_busy: assert property (s_accepted |=> $rose(busy_q));
  a_busy_origin:    assert property ($rose(busy_q) |-> $past(bus.accept) && !$past(bus.cancel));
  a_req_xor_cancel: assert property (!(request_q && cancel_q));
  a_grant_onehot0:  assert property ($onehot0(grant_q));

  c_accepted:      cover property (state_q == StWaitAcc && bus.accept);
  c_owner_cancel:  cover property (state_q == StWaitAcc && !bus.accept && own_cancel);
  c_timeout:       cover property (state_q == StWaitAcc && !bus.accept && !own_cancel && timed_out);
  c_accept_vs_can: cover property (state_q == StWaitAcc && bus.accept && own_cancel);
`else
  // Properties compiled out; behaviour is unchanged.
`endif

endmodule

// File: tb/tb_request_scheduler.sv
// Self-checking bench for request_scheduler: directed scenarios plus randomized
// transactions checked against a transaction-level round-robin/handshake model.
module tb_request_scheduler;
  localparam int unsigned NR = 4;
  localparam int unsigned TO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  request_scheduler_if #(.NUM_REQ(NR)) bus ();

  request_scheduler #(.NUM_REQ(NR), .ACCEPT_TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int passes = 0;
  int m_ptr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
  endtask

  // Advance one clock; sample 1 time unit after the edge and check invariants.
  task automatic step();
    @(posedge clk);
    #1;
    chk("req_and_cancel", 32'(bus.request & bus.cancel), 0);
    chk("grant_onehot0", 32'($onehot0(bus.grant)), 1);
  endtask

  function automatic int rr_pick(input logic [3:0] r, input int p);
    for (int i = 1; i <= int'(NR); i++) begin
      if (r[(p + i) % NR]) return (p + i) % NR;
    end
    return -1;
  endfunction

  // mode: 0 accept, 1 owner cancel, 2 timeout, 3 accept+owner cancel, 4 cancel then accept in CANCEL.
  // dly: WAIT_ACC cycles before the accept/cancel event; ddly: BUSY cycles before done.
  task automatic run_txn(input logic [3:0] reqv, input int mode, input int dly, input int ddly,
                         input bit noise);
    int         ow;
    logic [3:0] ob;
    bus.req        = reqv;
    bus.req_cancel = '0;
    bus.accept     = 1'b0;
    bus.done       = 1'b0;
    ow = rr_pick(reqv, m_ptr);
    ob = 4'(1 << ow);
    step();
    chk("grant", 32'(bus.grant), 32'(ob));
    chk("owner", 32'(bus.owner), ow);
    chk("request_pulse", 32'(bus.request), 1);
    chk("busy_at_request", 32'(bus.busy), 0);
    m_ptr = ow;
    if (noise) begin
      bus.req    = 4'($urandom) | ob;
      bus.accept = 1'b1;  // accept in the request cycle must be ignored
    end
    step();
    chk("request_low", 32'(bus.request), 0);
    chk("grant_hold_req", 32'(bus.grant), 32'(ob));
    bus.accept = 1'b0;
    case (mode)
      0, 3: begin
        repeat (dly) begin
          if (noise) begin
            bus.req_cancel = 4'($urandom) & ~ob;
            bus.done       = 1'($urandom);
          end
          step();
          chk("wait_no_cancel", 32'(bus.cancel), 0);
          chk("wait_no_busy", 32'(bus.busy), 0);
          chk("wait_grant", 32'(bus.grant), 32'(ob));
        end
        bus.req_cancel = (mode == 3) ? ob : 4'b0;
        bus.done       = 1'b0;
        bus.accept     = 1'b1;
        step();
        chk("busy_after_accept", 32'(bus.busy), 1);
        chk("no_cancel_on_accept", 32'(bus.cancel), 0);
        chk("busy_grant", 32'(bus.grant), 32'(ob));
        bus.accept = 1'b0;
        repeat (ddly) begin
          bus.req_cancel = noise ? 4'($urandom) : 4'b0;
          step();
          chk("busy_hold", 32'(bus.busy), 1);
          chk("busy_grant_hold", 32'(bus.grant), 32'(ob));
          chk("busy_no_cancel", 32'(bus.cancel), 0);
        end
        bus.req_cancel = '0;
        bus.done       = 1'b1;
        step();
        chk("busy_after_done", 32'(bus.busy), 0);
        chk("grant_after_done", 32'(bus.grant), 0);
        chk("idle_no_request", 32'(bus.request), 0);
        bus.done = 1'b0;
      end
      1, 4: begin
        repeat (dly) begin
          if (noise) begin
            bus.req_cancel = 4'($urandom) & ~ob;
            bus.done       = 1'($urandom);
          end
          step();
          chk("wait_no_cancel", 32'(bus.cancel), 0);
          chk("wait_grant", 32'(bus.grant), 32'(ob));
        end
        bus.req_cancel = ob | (noise ? 4'($urandom) : 4'b0);
        bus.done       = 1'b0;
        step();
        chk("cancel_pulse", 32'(bus.cancel), 1);
        chk("cancel_no_busy", 32'(bus.busy), 0);
        chk("cancel_grant_held", 32'(bus.grant), 32'(ob));
        bus.req_cancel = '0;
        bus.accept     = (mode == 4);
        step();
        chk("cancel_one_cycle", 32'(bus.cancel), 0);
        chk("grant_after_cancel", 32'(bus.grant), 0);
        chk("busy_after_cancel", 32'(bus.busy), 0);
        bus.accept = 1'b0;
      end
      default: begin
        for (int i = 1; i <= int'(TO); i++) begin
          if (noise) begin
            bus.req_cancel = 4'($urandom) & ~ob;
            bus.done       = 1'($urandom);
          end
          step();
          chk("timeout_cancel", 32'(bus.cancel), (i == int'(TO)) ? 1 : 0);
          chk("timeout_no_busy", 32'(bus.busy), 0);
        end
        bus.req_cancel = '0;
        bus.done       = 1'b0;
        step();
        chk("timeout_cancel_end", 32'(bus.cancel), 0);
        chk("timeout_grant_clear", 32'(bus.grant), 0);
        chk("timeout_busy", 32'(bus.busy), 0);
      end
    endcase
  endtask

  initial begin
    rst            = 1'b1;
    bus.req        = '0;
    bus.req_cancel = '0;
    bus.accept     = 1'b0;
    bus.done       = 1'b0;
    step();
    step();
    chk("rst_grant", 32'(bus.grant), 0);
    chk("rst_owner", 32'(bus.owner), 0);
    chk("rst_request", 32'(bus.request), 0);
    chk("rst_cancel", 32'(bus.cancel), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    rst   = 1'b0;
    m_ptr = NR - 1;

    run_txn(4'b0001, 0, 2, 4, 1'b0);
    repeat (5) run_txn(4'b1111, 0, 1, 0, 1'b0);
    run_txn(4'b0100, 1, 1, 0, 1'b0);
    run_txn(4'b1111, 0, 0, 1, 1'b0);
    run_txn(4'b0010, 2, 0, 0, 1'b0);
    run_txn(4'b1000, 3, 3, 1, 1'b0);
    run_txn(4'b0001, 4, 2, 0, 1'b0);
    run_txn(4'b0110, 0, TO - 1, 2, 1'b0);

    // Reset while BUSY with every requester pending.
    bus.req = 4'b1111;
    step();
    chk("pre_rst_grant", 32'(bus.grant), 32'(1 << rr_pick(4'b1111, m_ptr)));
    step();
    bus.accept = 1'b1;
    step();
    chk("pre_rst_busy", 32'(bus.busy), 1);
    bus.accept = 1'b0;
    rst        = 1'b1;
    step();
    chk("mid_rst_grant", 32'(bus.grant), 0);
    chk("mid_rst_request", 32'(bus.request), 0);
    chk("mid_rst_cancel", 32'(bus.cancel), 0);
    chk("mid_rst_busy", 32'(bus.busy), 0);
    chk("mid_rst_owner", 32'(bus.owner), 0);
    rst   = 1'b0;
    m_ptr = NR - 1;
    run_txn(4'b1111, 0, 0, 0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      int m;
      m = $urandom_range(0, 4);
      run_txn(4'($urandom_range(1, 15)), m, (m == 2) ? 0 : $urandom_range(0, TO - 1),
              $urandom_range(0, 4), 1'b1);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
